// File: rtl/button_event_decoder.sv
// Turns a debounced, clk-synchronous button level into one-cycle event strobes:
// press, release, click, double click, long press and auto-repeat while held.
module button_event_decoder #(
  parameter int CNT_W        = 24,
  parameter int LONG_TICKS   = 1000000,
  parameter int DBL_TICKS    = 250000,
  parameter int REPEAT_TICKS = 200000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_in,
  input  logic enable,
  output logic press_pulse,
  output logic release_pulse,
  output logic click,
  output logic double_click,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_TICKS - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);
  localparam bit               REP_ON    = (REPEAT_TICKS != 0);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [CNT_W-1:0] rcnt, rcnt_d;
  logic press_d, release_d, click_d, double_d, long_d, repeat_d, held_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d   = state;
    cnt_d     = cnt + 1'b1;
    rcnt_d    = '0;
    press_d   = 1'b0;
    release_d = 1'b0;
    click_d   = 1'b0;
    double_d  = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_d = '0;
        if (btn_in) begin
          state_d = PRESS1;
          press_d = 1'b1;
        end
      end
      PRESS1: begin
        // Release is tested first so it wins over the long-press threshold.
        if (!btn_in) begin
          state_d   = WAIT2;
          cnt_d     = '0;
          release_d = 1'b1;
        end else if (cnt == LONG_LAST) begin
          state_d = LONG;
          cnt_d   = '0;
          long_d  = 1'b1;
        end
      end
      WAIT2: begin
        if (btn_in) begin
          state_d = PRESS2;
          cnt_d   = '0;
          press_d = 1'b1;
        end else if (cnt == DBL_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          click_d = 1'b1;
        end
      end
      PRESS2: begin
        if (!btn_in) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
          double_d  = 1'b1;
        end else if (cnt == LONG_LAST) begin
          state_d = LONG;
          cnt_d   = '0;
          click_d = 1'b1;
          long_d  = 1'b1;
        end
      end
      LONG: begin
        // cnt is parked at zero here; only rcnt paces the repeat strobes.
        cnt_d  = '0;
        rcnt_d = rcnt + 1'b1;
        if (!btn_in) begin
          state_d   = IDLE;
          rcnt_d    = '0;
          release_d = 1'b1;
        end else if (REP_ON && rcnt == REP_LAST) begin
          rcnt_d   = '0;
          repeat_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Disable overrides everything, discarding any pending click.
    if (!enable) begin
      state_d   = IDLE;
      cnt_d     = '0;
      rcnt_d    = '0;
      press_d   = 1'b0;
      release_d = 1'b0;
      click_d   = 1'b0;
      double_d  = 1'b0;
      long_d    = 1'b0;
      repeat_d  = 1'b0;
    end

    held_d = (state_d == LONG);
  end

  // NOTE: sequential state uses non-blocking assignments and resets asynchronously on reset_n low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      rcnt          <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      click         <= 1'b0;
      double_click  <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      rcnt          <= rcnt_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      click         <= click_d;
      double_click  <= double_d;
      long_press    <= long_d;
      repeat_pulse  <= repeat_d;
      held          <= held_d;
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Self-checking bench for button_event_decoder: directed scenarios then random
// button activity, compared against a timestamp-based event model.
module tb_button_event_decoder;

  localparam int CNT_W = 8;
  localparam int LT    = 20;
  localparam int DT    = 8;
  localparam int RT    = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic btn_in = 1'b0;
  logic enable = 1'b1;
  logic press_pulse, release_pulse, click, double_click, long_press, repeat_pulse, held;

  int n_assert = 0;
  int n_fail   = 0;

  button_event_decoder #(
    .CNT_W(CNT_W), .LONG_TICKS(LT), .DBL_TICKS(DT), .REPEAT_TICKS(RT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .btn_in(btn_in), .enable(enable),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .click(click),
    .double_click(double_click), .long_press(long_press),
    .repeat_pulse(repeat_pulse), .held(held)
  );

  always #5 clk = ~clk;

  // Reference model: the button history expressed as timestamps of the last
  // press, release and long-hold start, measured in clock edges.
  int  edge_n = 0;
  bit  m_down, m_long, m_pending, m_second;
  int  t_press, t_release, t_long;
  logic e_press, e_release, e_click, e_double, e_long, e_repeat, e_held;

  function automatic void model_clear();
    m_down = 0; m_long = 0; m_pending = 0; m_second = 0;
    e_press = 0; e_release = 0; e_click = 0; e_double = 0;
    e_long = 0; e_repeat = 0; e_held = 0;
  endfunction

  function automatic void model_edge(bit b, bit en);
    edge_n++;
    e_press = 0; e_release = 0; e_click = 0; e_double = 0; e_long = 0; e_repeat = 0;
    if (!en) begin
      model_clear();
    end else if (m_long) begin
      if (!b) begin
        e_release = 1;
        m_long = 0;
      end else if (RT != 0 && ((edge_n - t_long) % RT) == 0) begin
        e_repeat = 1;
      end
    end else if (m_down) begin
      if (!b) begin
        e_release = 1;
        m_down = 0;
        if (m_second) begin
          e_double = 1;
          m_second = 0;
        end else begin
          m_pending = 1;
          t_release = edge_n;
        end
      end else if (edge_n - t_press == LT) begin
        e_long = 1;
        e_click = m_second;
        m_down = 0; m_second = 0; m_long = 1;
        t_long = edge_n;
      end
    end else if (m_pending) begin
      if (b) begin
        e_press = 1;
        m_pending = 0; m_down = 1; m_second = 1;
        t_press = edge_n;
      end else if (edge_n - t_release == DT) begin
        e_click = 1;
        m_pending = 0;
      end
    end else if (b) begin
      e_press = 1;
      m_down = 1; m_second = 0;
      t_press = edge_n;
    end
    e_held = m_long;
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @edge %0d: observed %b expected %b", tag, edge_n, obs, exp);
    end
  endtask

  task automatic check_all();
    check("press_pulse",   press_pulse,   e_press);
    check("release_pulse", release_pulse, e_release);
    check("click",         click,         e_click);
    check("double_click",  double_click,  e_double);
    check("long_press",    long_press,    e_long);
    check("repeat_pulse",  repeat_pulse,  e_repeat);
    check("held",          held,          e_held);
  endtask

  // Drive inputs between edges, let one edge happen, then compare #1 later.
  task automatic step(input bit b, input bit en);
    btn_in = b;
    enable = en;
    @(posedge clk);
    if (reset_n) model_edge(b, en);
    else model_clear();
    #1 check_all();
    @(negedge clk);
  endtask

  task automatic run(input bit b, input int cycles, input bit en = 1'b1);
    for (int i = 0; i < cycles; i++) step(b, en);
  endtask

  // Async reset pulse placed between edges; outputs must drop at once.
  task automatic async_reset();
    #2 reset_n = 1'b0;
    #1 model_clear();
    check_all();
    #1 reset_n = 1'b1;
  endtask

  int cnt_click, cnt_double, cnt_long, cnt_repeat;
  always @(posedge clk) begin
    #1;
    if (e_click)  cnt_click++;
    if (e_double) cnt_double++;
    if (e_long)   cnt_long++;
    if (e_repeat) cnt_repeat++;
  end

  initial begin
    model_clear();
    // Reset held low while the button toggles.
    #2 check_all();
    @(negedge clk);
    for (int i = 0; i < 6; i++) step(i[0], 1'b1);
    btn_in = 1'b0;
    reset_n = 1'b1;
    run(0, 4);

    // Single click.
    run(1, 5); run(0, 12);
    // Double click.
    run(1, 3); run(0, 4); run(1, 3); run(0, 12);
    // Second press lands exactly on the double-click timeout edge.
    run(1, 3); run(0, 8); run(1, 3); run(0, 12);
    // Long hold with auto-repeat.
    run(1, 40); run(0, 12);
    // Release on the long-press threshold edge.
    run(1, LT); run(0, 12);
    // Second press held into a long press.
    run(1, 2); run(0, 3); run(1, LT + 7); run(0, 12);
    // Disable during LONG, then re-enable with the button still down.
    run(1, 25); run(1, 3, 1'b0); run(1, 3); run(0, 12);
    // Reset during WAIT2: the pending click must vanish.
    run(1, 3); run(0, 2); async_reset(); run(0, 12);
    // Reset during LONG, button still held afterwards.
    run(1, 23); async_reset(); run(1, 3); run(0, 12);

    // Random button activity with occasional disables.
    for (int k = 0; k < 120; k++) begin
      int len;
      int kind;
      kind = int'($urandom_range(0, 9));
      if (kind < 5)      len = int'($urandom_range(1, 6));
      else if (kind < 8) len = int'($urandom_range(6, 12));
      else               len = int'($urandom_range(15, 32));
      if ($urandom_range(0, 19) == 0) run(k[0], int'($urandom_range(1, 3)), 1'b0);
      run(k[0], len);
    end
    run(0, 12);

    // The scenarios must actually have exercised every event kind.
    check("saw_click",  logic'(cnt_click  > 0), 1'b1);
    check("saw_double", logic'(cnt_double > 0), 1'b1);
    check("saw_long",   logic'(cnt_long   > 0), 1'b1);
    check("saw_repeat", logic'(cnt_repeat > 0), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
